// File: rtl/vga_pkg.sv
// VGA timing defaults, per-axis region encoding and the count-to-region lookup.
// Also holds the bundle of control signals that travels down the output pipeline.
package vga_pkg;

  localparam int H_ACT_DEF = 640;
  localparam int H_SS_DEF  = 656;
  localparam int H_SE_DEF  = 752;
  localparam int H_TOT_DEF = 800;
  localparam int V_ACT_DEF = 480;
  localparam int V_SS_DEF  = 490;
  localparam int V_SE_DEF  = 492;
  localparam int V_TOT_DEF = 525;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} region_t;

  typedef struct packed {
    logic de;
    logic hsyncN;
    logic vsyncN;
  } vidCtrl_t;

  localparam vidCtrl_t CTRL_IDLE = '{de: 1'b0, hsyncN: 1'b1, vsyncN: 1'b1};

  function automatic region_t region_of(input logic [9:0] count,
                                        input logic [9:0] act,
                                        input logic [9:0] ss,
                                        input logic [9:0] se);
    if (count < act)      return ACTIVE;
    else if (count < ss)  return FRONT;
    else if (count < se)  return SYNC;
    else                  return BACK;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping 10-bit counter, registered region state and raw sync.
// Advances only when en is high; region always describes the current count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACT = H_ACT_DEF,
  parameter int SS  = H_SS_DEF,
  parameter int SE  = H_SE_DEF,
  parameter int TOT = H_TOT_DEF
) (
  input  logic       Clk,
  input  logic       vgaRes,
  input  logic       en,
  output logic [9:0] count,
  output logic       atEnd,
  output region_t    region,
  output logic       syncRaw
);

  localparam logic [9:0] LAST = 10'(TOT - 1);

  logic [9:0] countNext;

  assign atEnd     = (count == LAST);
  assign countNext = atEnd ? 10'd0 : count + 10'd1;
  assign syncRaw   = (region == SYNC);

  // region is loaded from the same next-count as the counter, so both move together
  always_ff @(posedge Clk) begin
    if (vgaRes) begin
      count  <= 10'd0;
      region <= region_of(10'd0, 10'(ACT), 10'(SS), 10'(SE));
    end else if (en) begin
      count  <= countNext;
      region <= region_of(countNext, 10'(ACT), 10'(SS), 10'(SE));
    end
  end

endmodule

// File: rtl/vga_scan_arbiter.sv
// VGA raster sequencer sharing one single-port RAM: scan reads own every visible pixel tick, the writer gets all other Clk cycles.
// pixel/hsync_n/vsync_n/de leave 2 Clk after the scan read; VGA_BLANK_WRITE_ONLY_EN further restricts writes to vertical blanking.
module vga_scan_arbiter
  import vga_pkg::*;
#(
  parameter int PIX_DIV = 2,
  parameter int H_ACT   = H_ACT_DEF,
  parameter int H_SS    = H_SS_DEF,
  parameter int H_SE    = H_SE_DEF,
  parameter int H_TOT   = H_TOT_DEF,
  parameter int V_ACT   = V_ACT_DEF,
  parameter int V_SS    = V_SS_DEF,
  parameter int V_SE    = V_SE_DEF,
  parameter int V_TOT   = V_TOT_DEF,
  parameter int AW      = 19,
  parameter int DW      = 8
) (
  input  logic          Clk,
  input  logic          vgaRes,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [9:0]    h_count,
  output logic [9:0]    v_count,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          de,
  output logic [DW-1:0] pixel
);

  localparam int DIVW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(PIX_DIV - 1);

  logic [DIVW-1:0] div;
  logic            tick;
  logic [9:0]      hCount, vCount;
  logic            hAtEnd, vAtEnd;
  region_t         hRegion, vRegion;
  logic            hSyncRaw, vSyncRaw;
  logic            rawDe, scanSlot, frameWrap;
  logic [AW-1:0]   scanAddr;
  logic            wrWindow, wrGrant;
  vidCtrl_t        ctrlS1, ctrlS2;
  logic            scanD1;
  logic [DW-1:0]   pixelQ;

  assign tick = (div == '0);

  always_ff @(posedge Clk) begin
    if (vgaRes)               div <= '0;
    else if (div == DIV_LAST) div <= '0;
    else                      div <= div + 1'b1;
  end

  vga_axis_counter #(.ACT(H_ACT), .SS(H_SS), .SE(H_SE), .TOT(H_TOT)) uHoriz (
    .Clk(Clk), .vgaRes(vgaRes), .en(tick),
    .count(hCount), .atEnd(hAtEnd), .region(hRegion), .syncRaw(hSyncRaw)
  );

  vga_axis_counter #(.ACT(V_ACT), .SS(V_SS), .SE(V_SE), .TOT(V_TOT)) uVert (
    .Clk(Clk), .vgaRes(vgaRes), .en(tick && hAtEnd),
    .count(vCount), .atEnd(vAtEnd), .region(vRegion), .syncRaw(vSyncRaw)
  );

  assign rawDe     = (hRegion == ACTIVE) && (vRegion == ACTIVE);
  assign scanSlot  = tick && rawDe;
  assign frameWrap = tick && hAtEnd && vAtEnd;

  always_ff @(posedge Clk) begin
    if (vgaRes || frameWrap) scanAddr <= '0;
    else if (scanSlot)       scanAddr <= scanAddr + 1'b1;
  end

`ifdef VGA_BLANK_WRITE_ONLY_EN
  assign wrWindow = (vRegion != ACTIVE);
`else
  assign wrWindow = 1'b1;
`endif

  // A request seen during reset is dropped, not deferred
  assign wrGrant   = wr_valid && !scanSlot && wrWindow && !vgaRes;
  assign wr_ready  = wrGrant;
  assign mem_we    = wrGrant;
  assign mem_addr  = wrGrant ? wr_addr : scanAddr;
  assign mem_wdata = wr_data;

  // Control is captured on the tick so it stays aligned with the held pixel for a whole pixel period
  always_ff @(posedge Clk) begin
    if (vgaRes) begin
      ctrlS1 <= CTRL_IDLE;
      ctrlS2 <= CTRL_IDLE;
      scanD1 <= 1'b0;
      pixelQ <= '0;
    end else begin
      if (tick) ctrlS1 <= '{de: rawDe, hsyncN: !hSyncRaw, vsyncN: !vSyncRaw};
      ctrlS2 <= ctrlS1;
      scanD1 <= scanSlot;
      if (!ctrlS1.de)  pixelQ <= '0;
      else if (scanD1) pixelQ <= mem_rdata;
    end
  end

  assign h_count = hCount;
  assign v_count = vCount;
  assign hsync_n = ctrlS2.hsyncN;
  assign vsync_n = ctrlS2.vsyncN;
  assign de      = ctrlS2.de;
  assign pixel   = pixelQ;

endmodule

// File: tb/tb_vga_scan_arbiter.sv
// Self-checking bench for vga_scan_arbiter on a shrunken raster with a behavioural RAM.
module tb_vga_scan_arbiter;

  localparam int P  = 2;
  localparam int HA = 8,  HS = 10, HE = 13, HT = 16;
  localparam int VA = 4,  VS = 5,  VE = 7,  VT = 9;
  localparam int AW = 8,  DW = 8;
  localparam int FRAME = HT * VT * P;
  localparam int NW = 40;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          Clk = 1'b0;
  logic          vgaRes, wr_valid, wr_ready, mem_we;
  logic [AW-1:0] wr_addr, mem_addr;
  logic [DW-1:0] wr_data, mem_wdata, mem_rdata, pixel;
  logic [9:0]    h_count, v_count;
  logic          hsync_n, vsync_n, de;
  logic          ramInit;
  logic [DW-1:0] ram [0:255];
  int            cyc;
  int            total = 0;
  int            bad = 0;

  vga_scan_arbiter #(
    .PIX_DIV(P), .H_ACT(HA), .H_SS(HS), .H_SE(HE), .H_TOT(HT),
    .V_ACT(VA), .V_SS(VS), .V_SE(VE), .V_TOT(VT), .AW(AW), .DW(DW)
  ) dut (
    .Clk(Clk), .vgaRes(vgaRes), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .h_count(h_count), .v_count(v_count),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de), .pixel(pixel)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (ramInit) begin
      for (int a = 0; a < 256; a++) ram[a] <= 8'(a);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  always @(posedge Clk) begin
    if (vgaRes) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Raster model: ticks fall on cycles 0,P,2P..; counters advance after each tick.
  function automatic int ticksBefore(int c); return (c + P - 1) / P; endfunction
  function automatic int hAt(int c); return ticksBefore(c) % HT; endfunction
  function automatic int vAt(int c); return (ticksBefore(c) / HT) % VT; endfunction

  function automatic bit isScan(int c);
    int k;
    if (c % P != 0) return 1'b0;
    k = c / P;
    return ((k % HT) < HA) && (((k / HT) % VT) < VA);
  endfunction

  function automatic int scanAddrAt(int c);
    int k;
    k = c / P;
    return ((k / HT) % VT) * HA + (k % HT);
  endfunction

  // {de, hsync_n, vsync_n} seen at cycle c: the tick two cycles back, held for P cycles
  function automatic bit [2:0] outCtrl(int c);
    int k, h, v;
    if (c < 2) return 3'b011;
    k = (c - 2) / P;
    h = k % HT;
    v = (k / HT) % VT;
    return {(h < HA) && (v < VA), !((h >= HS) && (h < HE)), !((v >= VS) && (v < VE))};
  endfunction

  function automatic logic [DW-1:0] wdat(int i); return 8'(i * 7 + 3); endfunction

  task automatic do_reset();
    @(posedge Clk); #1;
    vgaRes = 1'b1;
    wr_valid = 1'b0;
    @(posedge Clk); #1;
    vgaRes = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (37) @(posedge Clk);
    #1;
    vgaRes = 1'b1;
    wr_valid = 1'b1;
    wr_addr = 8'd200;
    wr_data = 8'h3C;
    @(negedge Clk);
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL rst_cycle_wr_ready got=%b want=0", wr_ready); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_cycle_mem_we got=%b want=0", mem_we); end
    @(posedge Clk); #1;
    vgaRes = 1'b0;
    @(negedge Clk);
    total++; if (h_count !== 10'd0) begin bad++; $display("FAIL rst_h got=%0d want=0", h_count); end
    total++; if (v_count !== 10'd0) begin bad++; $display("FAIL rst_v got=%0d want=0", v_count); end
    total++; if (hsync_n !== 1'b1) begin bad++; $display("FAIL rst_hsync_n got=%b want=1", hsync_n); end
    total++; if (vsync_n !== 1'b1) begin bad++; $display("FAIL rst_vsync_n got=%b want=1", vsync_n); end
    total++; if (de !== 1'b0) begin bad++; $display("FAIL rst_de got=%b want=0", de); end
    total++; if (pixel !== 8'h00) begin bad++; $display("FAIL rst_pixel got=%0h want=0", pixel); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready got=%b want=0", wr_ready); end
    @(posedge Clk); #1;
    wr_valid = 1'b0;
    @(negedge Clk);
    total++; if (ram[200] !== 8'd200) begin bad++; $display("FAIL rst_dropped_write ram[200] got=%0h want=c8", ram[200]); end
  endtask

  task automatic test_frame_timing();
    int hsLow, vsLow;
    bit [2:0] e;
    hsLow = 0;
    vsLow = 0;
    do_reset();
    for (int c = 0; c < FRAME; c++) begin
      @(negedge Clk);
      e = outCtrl(c);
      total++; if (h_count !== 10'(hAt(c))) begin bad++; $display("FAIL frame_h cyc=%0d got=%0d want=%0d", c, h_count, hAt(c)); end
      total++; if (v_count !== 10'(vAt(c))) begin bad++; $display("FAIL frame_v cyc=%0d got=%0d want=%0d", c, v_count, vAt(c)); end
      total++; if ({de, hsync_n, vsync_n} !== e) begin bad++; $display("FAIL frame_ctrl cyc=%0d got=%b want=%b", c, {de, hsync_n, vsync_n}, e); end
      if (hsync_n === 1'b0) hsLow++;
      if (vsync_n === 1'b0) vsLow++;
    end
    @(negedge Clk);
    total++; if (h_count !== 10'd0 || v_count !== 10'd0) begin bad++; $display("FAIL frame_len h=%0d v=%0d want 0/0", h_count, v_count); end
    total++; if (hsLow != (HE - HS) * VT * P) begin bad++; $display("FAIL hsync_low_cycles got=%0d want=%0d", hsLow, (HE - HS) * VT * P); end
    total++; if (vsLow != (VE - VS) * HT * P) begin bad++; $display("FAIL vsync_low_cycles got=%0d want=%0d", vsLow, (VE - VS) * HT * P); end
  endtask

  task automatic test_pixels();
    logic [DW-1:0] expQ[$];
    int run, lineStarts;
    logic prevDe;
    run = 0;
    lineStarts = 0;
    prevDe = 1'b0;
    do_reset();
    for (int i = 0; i < HA * VA; i++) expQ.push_back(8'(i));
    for (int c = 0; c < FRAME; c++) begin
      @(negedge Clk);
      if (de === 1'b1) begin
        total++;
        if (expQ.size() == 0) begin
          bad++; $display("FAIL pix_extra cyc=%0d got=%0h want=none", c, pixel);
        end else begin
          if (pixel !== expQ[0]) begin bad++; $display("FAIL pix_value cyc=%0d got=%0h want=%0h", c, pixel, expQ[0]); end
          run++;
          if (run == P) begin void'(expQ.pop_front()); run = 0; end
        end
        if (prevDe !== 1'b1) begin
          lineStarts++;
          if (lineStarts == 2) begin
            total++; if (pixel !== 8'(HA)) begin bad++; $display("FAIL line1_start got=%0h want=%0h", pixel, HA); end
          end
        end
      end else begin
        total++; if (pixel !== 8'h00) begin bad++; $display("FAIL pix_blank cyc=%0d got=%0h want=0", c, pixel); end
      end
      prevDe = de;
    end
    total++; if (expQ.size() != 0) begin bad++; $display("FAIL pix_missing left=%0d want=0", expQ.size()); end
    total++; if (lineStarts != VA) begin bad++; $display("FAIL de_lines got=%0d want=%0d", lineStarts, VA); end
  endtask

  task automatic test_writes();
    wr_t wq[$];
    wr_t done[$];
    wr_t w;
    int i;
    bit scan, expRdy, took;
    i = 0;
    do_reset();
    w.a = 8'd100;
    w.d = wdat(0);
    wr_addr = w.a;
    wr_data = w.d;
    wr_valid = 1'b1;
    wq.push_back(w);
    for (int c = 0; c < 2 * FRAME && i < NW; c++) begin
      @(negedge Clk);
      scan = isScan(cyc);
      expRdy = !scan;
`ifdef VGA_BLANK_WRITE_ONLY_EN
      expRdy = expRdy && (vAt(cyc) >= VA);
`endif
      total++; if (wr_ready !== expRdy) begin bad++; $display("FAIL wr_ready cyc=%0d got=%b want=%b", cyc, wr_ready, expRdy); end
      if (scan) begin
        total++;
        if (mem_we !== 1'b0 || mem_addr !== 8'(scanAddrAt(cyc))) begin
          bad++; $display("FAIL scan_port cyc=%0d we=%b addr=%0d want we=0 addr=%0d", cyc, mem_we, mem_addr, scanAddrAt(cyc));
        end
      end
      took = (wr_ready === 1'b1);
      if (took) begin
        total++;
        if (mem_we !== 1'b1 || mem_addr !== wq[0].a || mem_wdata !== wq[0].d) begin
          bad++; $display("FAIL wr_port cyc=%0d we=%b addr=%0d data=%0h want we=1 addr=%0d data=%0h", cyc, mem_we, mem_addr, mem_wdata, wq[0].a, wq[0].d);
        end
        done.push_back(wq.pop_front());
        i++;
      end
      @(posedge Clk); #1;
      if (took) begin
        if (i < NW) begin
          w.a = 8'(100 + i);
          w.d = wdat(i);
          wr_addr = w.a;
          wr_data = w.d;
          wq.push_back(w);
        end else begin
          wr_valid = 1'b0;
        end
      end
    end
    wr_valid = 1'b0;
    total++; if (i != NW) begin bad++; $display("FAIL wr_timeout got=%0d want=%0d", i, NW); end
    @(negedge Clk);
    foreach (done[j]) begin
      total++;
      if (ram[done[j].a] !== done[j].d) begin bad++; $display("FAIL wr_landed addr=%0d got=%0h want=%0h", done[j].a, ram[done[j].a], done[j].d); end
    end
  endtask

`ifdef VGA_BLANK_WRITE_ONLY_EN
  task automatic test_blank_write();
    int expFirst, gotFirst;
    logic [9:0] hG, vG;
    expFirst = -1;
    gotFirst = -1;
    hG = '1;
    vG = '1;
    for (int c = HT * P + 5; c < 2 * FRAME; c++) begin
      if (vAt(c) >= VA && !isScan(c)) begin expFirst = c; break; end
    end
    do_reset();
    repeat (HT * P + 5) @(posedge Clk);
    #1;
    wr_addr = 8'd150;
    wr_data = 8'h5A;
    wr_valid = 1'b1;
    for (int n = 0; n < 2 * FRAME; n++) begin
      @(negedge Clk);
      if (wr_ready === 1'b1) begin gotFirst = cyc; hG = h_count; vG = v_count; break; end
    end
    @(posedge Clk); #1;
    wr_valid = 1'b0;
    total++; if (gotFirst != expFirst) begin bad++; $display("FAIL blank_grant_cycle got=%0d want=%0d", gotFirst, expFirst); end
    total++; if (hG !== 10'd0 || vG !== 10'(VA)) begin bad++; $display("FAIL blank_grant_pos h=%0d v=%0d want 0/%0d", hG, vG, VA); end
    @(negedge Clk);
    total++; if (ram[150] !== 8'h5A) begin bad++; $display("FAIL blank_write ram[150] got=%0h want=5a", ram[150]); end
  endtask
`endif

  task automatic test_scan_overwrite();
    logic [DW-1:0] pq[$];
    logic [DW-1:0] e;
    bit got;
    do_reset();
    pq.push_back(8'h00);
    pq.push_back(8'h00);
    repeat (3) @(negedge Clk);
    e = pq.pop_front();
    total++; if (de !== 1'b1 || pixel !== e) begin bad++; $display("FAIL ovw_first de=%b pix=%0h want de=1 pix=%0h", de, pixel, e); end
    @(posedge Clk); #1;
    wr_addr = 8'd0;
    wr_data = 8'hA5;
    wr_valid = 1'b1;
    pq.push_back(8'hA5);
    @(negedge Clk);
    e = pq.pop_front();
    total++; if (de !== 1'b1 || pixel !== e) begin bad++; $display("FAIL ovw_current_pass de=%b pix=%0h want de=1 pix=%0h", de, pixel, e); end
    got = (wr_ready === 1'b1);
    for (int n = 0; n < 2 * FRAME && !got; n++) begin
      @(negedge Clk);
      got = (wr_ready === 1'b1);
    end
    @(posedge Clk); #1;
    wr_valid = 1'b0;
    total++; if (!got) begin bad++; $display("FAIL ovw_timeout got=0 want=1"); end
    do @(negedge Clk); while (cyc < FRAME + 2);
    e = pq.pop_front();
    total++; if (de !== 1'b1 || pixel !== e) begin bad++; $display("FAIL ovw_next_frame de=%b pix=%0h want de=1 pix=%0h", de, pixel, e); end
    total++; if (ram[0] !== 8'hA5) begin bad++; $display("FAIL ovw_ram got=%0h want=a5", ram[0]); end
  endtask

  initial begin
    vgaRes = 1'b1;
    wr_valid = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    ramInit = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    ramInit = 1'b0;
    test_reset();
    test_frame_timing();
    test_pixels();
    test_writes();
`ifdef VGA_BLANK_WRITE_ONLY_EN
    test_blank_write();
`endif
    test_scan_overwrite();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
